xray_line_reader: RTL

Readout-side companion to the sensor clock/reset generator. It watches the SENCLK and SENRST lines driven to the X-ray line sensor and captures one parallel ADC word per SENCLK period after each SENRST line start. Captured pixels are tagged with their index and buffered in a small FIFO, which feeds downstream logic over a valid/ready stream. All logic runs in the 100 MHz CLK domain.

---
 rtl/xray_line_reader.sv | 107 ++++++++++
 1 files changed

// File: rtl/xray_line_reader.sv
// xray_line_reader: captures one ADC word per SENCLK period after each SENRST
// line start and streams index-tagged pixels out through a small FIFO.
module xray_line_reader #(
  parameter int PIXELS     = 64,
  parameter int DATA_W     = 12,
  parameter int SAMPLE_DLY = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      senclk,
  input  logic                      senrst,
  input  logic [DATA_W-1:0]         adc_data,
  output logic [DATA_W-1:0]         pix_data,
  output logic [$clog2(PIXELS)-1:0] pix_idx,
  output logic                      pix_last,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      line_done,
  output logic                      line_err,
  output logic                      ovf
);
  localparam int IW = $clog2(PIXELS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + IW + 1;
  localparam logic [3:0] DLY0 = 4'(SAMPLE_DLY == 0 ? 0 : SAMPLE_DLY - 1);

  typedef enum logic [1:0] {IDLE, ARMED, DELAY, CAPTURE} state_t;

  state_t        state;
  logic [2:0]    clk_sr, rst_sr;
  logic [IW-1:0] cnt;
  logic [3:0]    dly;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wp, rp;
  logic          clk_edge, rst_edge, last, empty, full, rd, cap, wr;

  // [0],[1] synchronize, [2] holds the previous synchronized level
  assign clk_edge = clk_sr[1] & ~clk_sr[2];
  assign rst_edge = rst_sr[1] & ~rst_sr[2];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_sr <= '0;
      rst_sr <= '0;
    end else begin
      clk_sr <= {clk_sr[1:0], senclk};
      rst_sr <= {rst_sr[1:0], senrst};
    end

  assign last      = cnt == IW'(PIXELS - 1);
  assign cap       = state == CAPTURE && !rst_edge;
  assign rd        = pix_valid && pix_ready;
  assign wr        = cap && (!full || rd);
  assign line_done = cap && last;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dly      <= '0;
      line_err <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      line_err <= rst_edge && state != IDLE;
      if (rst_edge) begin
        state <= ARMED;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else begin
        case (state)
          ARMED: if (clk_edge) begin
            state <= SAMPLE_DLY == 0 ? CAPTURE : DELAY;
            dly   <= DLY0;
          end
          DELAY: begin
            state <= dly == 4'd0 ? CAPTURE : DELAY;
            dly   <= dly - 4'd1;
          end
          CAPTURE: begin
            if (!wr) ovf <= 1'b1;
            state <= last ? IDLE : ARMED;
            cnt   <= last ? '0 : cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end

  // Extra pointer bit distinguishes full from empty
  assign empty     = wp == rp;
  assign full      = wp == {~rp[AW], rp[AW-1:0]};
  assign pix_valid = !empty;
  assign {pix_data, pix_idx, pix_last} = pix_valid ? mem[rp[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end

  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= {adc_data, cnt, last};
endmodule
